// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter: default
// widths, the starvation FSM state encoding and the hard-wired zero register.
package rf_arb_pkg;

    localparam int AW_DEF   = 5;
    localparam int DW_DEF   = 32;
    localparam int REG_ZERO = 0;

    // States of the starvation guard (only used when RF_ARB_STARVE_EN is defined)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rf_arb_fifo.sv
// Synchronous FIFO holding MDU results (destination + data) until a write
// slot on the register file is free. Pointers wrap modulo DEPTH; a separate
// full flag disambiguates equal pointers.
module rf_arb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic             full_r;
    logic             do_push_s;
    logic             do_pop_s;
    logic             empty_s;

    assign empty_s   = (wr_ptr_r == rd_ptr_r) && !full_r;
    assign do_push_s = push && !full_r;
    assign do_pop_s  = pop && !empty_s;
    assign head      = mem_r[rd_ptr_r];
    assign full      = full_r;
    assign empty     = empty_s;

    // Storage array: written at the tail on an accepted push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and full-flag bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            full_r   <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            if (do_push_s && !do_pop_s && ((wr_ptr_r + PW'(1)) == rd_ptr_r)) begin
                full_r <= 1'b1;
            end else if (do_pop_s && !do_push_s) begin
                full_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter. The WB stage owns the single write port;
// MDU results are queued in a small FIFO and written in free WB slots. A
// scoreboard of pending MDU destinations drives a read-hazard stall to ID.
// Optional macro RF_ARB_STARVE_EN adds a starvation guard that holds WB after
// STARVE_LIMIT consecutive blocked cycles so the FIFO head can drain.
module rf_wport_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wb_valid,
    input  logic [AW-1:0]        wb_addr,
    input  logic [DW-1:0]        wb_data,
    output logic                 wb_hold,
    input  logic                 mdu_issue,
    input  logic [AW-1:0]        mdu_issue_addr,
    input  logic                 mdu_valid,
    input  logic [AW-1:0]        mdu_addr,
    input  logic [DW-1:0]        mdu_data,
    output logic                 mdu_ready,
    input  logic [AW-1:0]        rd_addr1,
    input  logic [AW-1:0]        rd_addr2,
    output logic                 hazard_stall,
    output logic [(1<<AW)-1:0]   pending_mask,
    output logic                 RegWrite,
    output logic [AW-1:0]        W_addr,
    output logic [DW-1:0]        W_data
);

    localparam int NREG = 1 << AW;
    localparam int FW   = AW + DW;
    localparam logic [NREG-1:0] ONE_BIT = {{(NREG-1){1'b0}}, 1'b1};

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (STARVE_LIMIT < 1)) begin : g_param_check
        $error("rf_wport_arbiter: DEPTH must be a power of 2 >= 2 and STARVE_LIMIT >= 1");
    end

    logic            wb_busy_s;
    logic            hold_s;
    logic            wb_sel_s;
    logic            fifo_sel_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic            push_s;
    logic [FW-1:0]   fifo_head_s;
    logic [AW-1:0]   head_addr_s;
    logic [DW-1:0]   head_data_s;
    logic [NREG-1:0] set_mask_s;
    logic [NREG-1:0] clr_mask_s;
    logic [NREG-1:0] pend_next_s;

    // A WB write to r0 is a no-op and leaves the slot free for the FIFO.
    assign wb_busy_s   = wb_valid && (wb_addr != AW'(REG_ZERO));
    assign wb_sel_s    = wb_busy_s && !hold_s;
    assign fifo_sel_s  = !wb_sel_s && !fifo_empty_s;
    assign head_addr_s = fifo_head_s[FW-1:DW];
    assign head_data_s = fifo_head_s[DW-1:0];

    // Results to r0 are acknowledged but never stored.
    assign push_s    = mdu_valid && !fifo_full_s && (mdu_addr != AW'(REG_ZERO));
    assign mdu_ready = !fifo_full_s;
    assign wb_hold   = hold_s;

    rf_arb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data ({mdu_addr, mdu_data}),
        .pop       (fifo_sel_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Write-port mux: WB first, then FIFO head, else idle; forced idle in reset
    always_comb begin
        RegWrite = 1'b0;
        W_addr   = {AW{1'b0}};
        W_data   = {DW{1'b0}};
        if (!rst_n) begin
            RegWrite = 1'b0;
        end else if (wb_sel_s) begin
            RegWrite = 1'b1;
            W_addr   = wb_addr;
            W_data   = wb_data;
        end else if (fifo_sel_s) begin
            RegWrite = 1'b1;
            W_addr   = head_addr_s;
            W_data   = head_data_s;
        end else begin
            RegWrite = 1'b0;
        end
    end

    // Scoreboard next value: issue sets, FIFO-head write clears, set wins, r0 stays clear
    always_comb begin
        set_mask_s  = (mdu_issue && (mdu_issue_addr != AW'(REG_ZERO)))
                      ? (ONE_BIT << mdu_issue_addr) : {NREG{1'b0}};
        clr_mask_s  = fifo_sel_s ? (ONE_BIT << head_addr_s) : {NREG{1'b0}};
        pend_next_s = ((pending_mask & ~clr_mask_s) | set_mask_s) & ~ONE_BIT;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_mask <= {NREG{1'b0}};
        end else begin
            pending_mask <= pend_next_s;
        end
    end

    assign hazard_stall = pending_mask[rd_addr1] | pending_mask[rd_addr2];

`ifdef RF_ARB_STARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    arb_state_e    state_r;
    arb_state_e    state_next_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic          blocked_s;

    // Head is blocked when it has data but WB took the port this cycle.
    assign blocked_s = !fifo_empty_s && wb_sel_s;
    assign hold_s    = (state_r == ST_FORCE);

    // Starvation FSM state and blocked-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Starvation FSM next state: count blocked cycles, force one pop at the limit
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (blocked_s) begin
                    cnt_next_s = CW'(1);
                    if (STARVE_LIMIT <= 1) begin
                        state_next_s = ST_FORCE;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end else begin
                    cnt_next_s   = {CW{1'b0}};
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (blocked_s) begin
                    cnt_next_s = cnt_r + CW'(1);
                    if (cnt_r >= CW'(STARVE_LIMIT - 1)) begin
                        state_next_s = ST_FORCE;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end else begin
                    cnt_next_s   = {CW{1'b0}};
                    state_next_s = ST_IDLE;
                end
            end
            ST_FORCE: begin
                // The head always pops in FORCE, so one cycle here suffices.
                cnt_next_s   = {CW{1'b0}};
                state_next_s = ST_IDLE;
            end
            default: begin
                cnt_next_s   = {CW{1'b0}};
                state_next_s = ST_IDLE;
            end
        endcase
    end
`else
    assign hold_s = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Bench for rf_wport_arbiter: directed scenarios followed by random traffic,
// all checked against a queue/array reference model of the arbitration rules.
module tb_rf_wport_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;
    localparam int AW           = 5;
    localparam int DW           = 32;
    localparam int NREG         = 32;

    logic            clk;
    logic            rst_n;
    logic            wb_valid;
    logic [AW-1:0]   wb_addr;
    logic [DW-1:0]   wb_data;
    logic            wb_hold;
    logic            mdu_issue;
    logic [AW-1:0]   mdu_issue_addr;
    logic            mdu_valid;
    logic [AW-1:0]   mdu_addr;
    logic [DW-1:0]   mdu_data;
    logic            mdu_ready;
    logic [AW-1:0]   rd_addr1;
    logic [AW-1:0]   rd_addr2;
    logic            hazard_stall;
    logic [NREG-1:0] pending_mask;
    logic            RegWrite;
    logic [AW-1:0]   W_addr;
    logic [DW-1:0]   W_data;

    rf_wport_arbiter #(
        .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .AW(AW), .DW(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_hold(wb_hold),
        .mdu_issue(mdu_issue), .mdu_issue_addr(mdu_issue_addr),
        .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .hazard_stall(hazard_stall),
        .pending_mask(pending_mask),
        .RegWrite(RegWrite), .W_addr(W_addr), .W_data(W_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file committing on the falling edge
    logic [DW-1:0] rf [NREG];
    always @(negedge clk) begin
        if (RegWrite) rf[W_addr] <= W_data;
    end

    // Reference model state
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    bit            pend[NREG];
    int            run;
    bit            force_m;
    logic [AW-1:0] issued[$];
    int            pass_cnt = 0;
    int            total_cnt = 0;
    int            fail_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        issued.delete();
        for (int i = 0; i < NREG; i++) pend[i] = 1'b0;
        run = 0;
        force_m = 1'b0;
    endtask

    // Expected outputs for the current inputs and model state
    task automatic check_outputs();
        bit              busy;
        logic            e_we;
        logic [AW-1:0]   e_a;
        logic [DW-1:0]   e_d;
        logic [NREG-1:0] pm;
        busy = wb_valid && (wb_addr != 5'd0);
        if (busy && !force_m) begin
            e_we = 1'b1; e_a = wb_addr; e_d = wb_data;
        end else if (q.size() > 0) begin
            e_we = 1'b1; e_a = q[0].a; e_d = q[0].d;
        end else begin
            e_we = 1'b0; e_a = 5'd0; e_d = 32'd0;
        end
        for (int i = 0; i < NREG; i++) pm[i] = pend[i];
        chk("RegWrite", 64'(RegWrite), 64'(e_we));
        chk("W_addr", 64'(W_addr), 64'(e_a));
        chk("W_data", 64'(W_data), 64'(e_d));
        chk("mdu_ready", 64'(mdu_ready), 64'(q.size() < DEPTH));
        chk("hazard_stall", 64'(hazard_stall), 64'(pend[rd_addr1] | pend[rd_addr2]));
        chk("pending_mask", 64'(pending_mask), 64'(pm));
        chk("wb_hold", 64'(wb_hold), 64'(force_m));
    endtask

    // Advance the model by one clock using the inputs of the closing cycle
    task automatic model_clock();
        bit   busy;
        bit   popped;
        bit   accept;
        ent_t e;
        busy   = wb_valid && (wb_addr != 5'd0);
        popped = !(busy && !force_m) && (q.size() > 0);
        accept = mdu_valid && (q.size() < DEPTH) && (mdu_addr != 5'd0);
`ifdef RF_ARB_STARVE_EN
        if (force_m) begin
            force_m = 1'b0;
            run = 0;
        end else if ((q.size() > 0) && busy) begin
            run++;
            if (run >= STARVE_LIMIT) force_m = 1'b1;
        end else begin
            run = 0;
        end
`endif
        if (popped) begin
            pend[q[0].a] = 1'b0;
            void'(q.pop_front());
        end
        if (mdu_issue && (mdu_issue_addr != 5'd0)) pend[mdu_issue_addr] = 1'b1;
        if (accept) begin
            e.a = mdu_addr;
            e.d = mdu_data;
            q.push_back(e);
        end
    endtask

    task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic iss, input logic [AW-1:0] ia,
                        input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                        input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        wb_valid = wv; wb_addr = wa; wb_data = wd;
        mdu_issue = iss; mdu_issue_addr = ia;
        mdu_valid = mv; mdu_addr = ma; mdu_data = md;
        rd_addr1 = r1; rd_addr2 = r2;
        #1;
        check_outputs();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          wv, iss, mv;
        logic [AW-1:0] wa, ia, ma;
        logic [DW-1:0] wd, md;

        // Reset state
        rst_n = 1'b0;
        wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        mdu_issue = 1'b0; mdu_issue_addr = 5'd0;
        mdu_valid = 1'b0; mdu_addr = 5'd0; mdu_data = 32'd0;
        rd_addr1 = 5'd0; rd_addr2 = 5'd0;
        model_reset();
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // WB only: same-cycle write, regfile commits at the negedge
        step(1'b1, 5'd8, 32'hDEAD, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk("rf_r8", 64'(rf[8]), 64'h0000_DEAD);

        // Idle-slot drain of a single MDU result
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd16, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk("pend16_set", 64'(pending_mask[16]), 64'd1);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd16, 32'h1234, 5'd0, 5'd0);
        idle();
        chk("pend16_clr", 64'(pending_mask[16]), 64'd0);
        chk("rf_r16", 64'(rf[16]), 64'h1234);

        // Full FIFO with WB busy
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        step(1'b1, 5'd20, 32'hA0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h33, 5'd0, 5'd0);
        step(1'b1, 5'd20, 32'hA1, 1'b0, 5'd0, 1'b1, 5'd4, 32'h44, 5'd0, 5'd0);
        chk("full_ready", 64'(mdu_ready), 64'd0);
        step(1'b1, 5'd20, 32'hA2, 1'b0, 5'd0, 1'b1, 5'd5, 32'h55, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'h55, 5'd0, 5'd0);
        chk("after_pop_ready", 64'(mdu_ready), 64'd1);
        step(1'b1, 5'd21, 32'hA3, 1'b0, 5'd0, 1'b1, 5'd5, 32'h55, 5'd0, 5'd0);
        repeat (3) idle();
        chk("full_drained", 64'(pending_mask), 64'd0);
        chk("rf_r5", 64'(rf[5]), 64'h55);

        // Hazard on r9 and drain through a WB write to r0
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
        chk("hazard_set", 64'(hazard_stall), 64'd1);
        step(1'b1, 5'd20, 32'hB0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h99, 5'd9, 5'd0);
        step(1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
        chk("hazard_clr", 64'(hazard_stall), 64'd0);
        chk("rf_r9", 64'(rf[9]), 64'h99);

        // Starvation: one FIFO entry, WB busy every cycle
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        step(1'b1, 5'd21, 32'hC0, 1'b0, 5'd0, 1'b1, 5'd12, 32'hC0DE, 5'd0, 5'd0);
        repeat (4) step(1'b1, 5'd22, 32'hC1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
`ifdef RF_ARB_STARVE_EN
        chk("starve_hold", 64'(wb_hold), 64'd1);
        chk("starve_head_addr", 64'(W_addr), 64'd12);
        step(1'b1, 5'd22, 32'hC1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk("starve_release", 64'(wb_hold), 64'd0);
        chk("starve_wb_addr", 64'(W_addr), 64'd22);
        chk("starve_wb_data", 64'(W_data), 64'hC1);
        chk("rf_r12", 64'(rf[12]), 64'hC0DE);
`else
        chk("nostarve_hold", 64'(wb_hold), 64'd0);
        chk("nostarve_wb_addr", 64'(W_addr), 64'd22);
`endif
        repeat (2) idle();

        // Reset in the middle of a drain
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        step(1'b1, 5'd23, 32'hD0, 1'b0, 5'd0, 1'b1, 5'd6, 32'h66, 5'd0, 5'd0);
        step(1'b1, 5'd23, 32'hD1, 1'b0, 5'd0, 1'b1, 5'd7, 32'h77, 5'd0, 5'd0);
        mdu_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_regwrite", 64'(RegWrite), 64'd0);
        model_reset();
        wb_valid = 1'b0; wb_addr = 5'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", 64'(mdu_ready), 64'd1);
        chk("rst_pending", 64'(pending_mask), 64'd0);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            iss = 1'b0; ia = 5'd0;
            if ($urandom_range(0, 2) == 0) begin
                ia = 5'($urandom_range(1, NREG - 1));
                if (!pend[ia]) iss = 1'b1;
                else ia = 5'd0;
            end
            mv = 1'b0; ma = 5'd0; md = $urandom;
            if ((issued.size() > 0) && ($urandom_range(0, 2) != 0)) begin
                mv = 1'b1;
                ma = issued[0];
            end else if ($urandom_range(0, 15) == 0) begin
                mv = 1'b1;
            end
            if (mv && (ma != 5'd0) && (q.size() < DEPTH)) void'(issued.pop_front());
            wv = ($urandom_range(0, 9) < 6);
            wa = 5'($urandom_range(0, NREG - 1));
            if (pend[wa]) wa = 5'd0;
            wd = $urandom;
            step(wv, wa, wd, iss, ia, mv, ma, md,
                 5'($urandom_range(0, NREG - 1)), 5'($urandom_range(0, NREG - 1)));
            if (iss) issued.push_back(ia);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
